// File: rtl/lcd_frame_scheduler_if.sv
// ----------------------------------------------------------------------------
// lcd_frame_scheduler_if
//   Bundles the character-write request bus between the application
//   requesters and the LCD frame scheduler.
//
//   Handshake: each requester raises wr_req[i] and holds wr_addr[i] and
//   wr_char[i] stable. The write is taken on the rising clk edge where
//   wr_req[i] && wr_gnt[i]. The requester may change its request only
//   after it has seen that grant. wr_gnt is combinational, one-hot or zero.
//   clear_req is a single-cycle command. It is never stalled, and it
//   suppresses all grants in the cycle where it is high.
//
//   Signals
//     wr_req    [NREQ]      per-requester write request (level)
//     wr_addr   [NREQ][5]   per-requester character position 0..31
//     wr_char   [NREQ][8]   per-requester ASCII code
//     wr_gnt    [NREQ]      one-hot grant from the scheduler
//     clear_req [1]         fill the shadow frame with spaces
//
//   Modports
//     master : application side (drives requests, sees grants)
//     slave  : scheduler side
// ----------------------------------------------------------------------------
interface lcd_frame_scheduler_if #(
    parameter int NREQ = 2
);
    logic [NREQ-1:0]       wr_req;
    logic [NREQ-1:0][4:0]  wr_addr;
    logic [NREQ-1:0][7:0]  wr_char;
    logic [NREQ-1:0]       wr_gnt;
    logic                  clear_req;

    modport master (
        output wr_req,
        output wr_addr,
        output wr_char,
        output clear_req,
        input  wr_gnt
    );

    modport slave (
        input  wr_req,
        input  wr_addr,
        input  wr_char,
        input  clear_req,
        output wr_gnt
    );
endinterface

// File: rtl/lcd_frame_scheduler.sv
// ----------------------------------------------------------------------------
// lcd_frame_scheduler
//   Owns the 32-character text frame for a 16x2 character LCD.
//
//   Operation
//     Single-character writes from NREQ requesters are round-robin
//     arbitrated into a shadow frame. When the shadow frame is dirty, the
//     refresh period has elapsed and the LCD driver is idle, the shadow
//     frame is copied to the display frame in one cycle. UpdateLCD then
//     pulses for one cycle. Commits are rate-limited to one per
//     REFRESH_CYCLES clocks.
//
//   Parameters
//     NREQ            number of write requesters (1..8)
//     REFRESH_CYCLES  minimum clocks between commits (>= 4)
//
//   Ports
//     clk          in   master clock
//     reset        in   asynchronous, active-high reset
//     req_if       --   write request bus (slave modport), see interface
//     LCDBusy      in   LCD driver busy; commits are held off while high
//     ASCII        out  display frame [0:31] of 8-bit ASCII codes
//     UpdateLCD    out  registered 1-cycle pulse: ASCII is new and stable
//     Pending      out  shadow frame differs from the last commit
//     dbg_state_o  out  current FSM state (S_IDLE/S_COMMIT/S_PULSE/S_HOLD)
// ----------------------------------------------------------------------------
module lcd_frame_scheduler #(
    parameter int NREQ           = 2,
    parameter int REFRESH_CYCLES = 2500000
) (
    input  logic                        clk,
    input  logic                        reset,
    lcd_frame_scheduler_if.slave        req_if,
    input  logic                        LCDBusy,
    output logic [7:0]                  ASCII [0:31],
    output logic                        UpdateLCD,
    output logic                        Pending,
    output logic [1:0]                  dbg_state_o
);

    localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW   = $clog2(REFRESH_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_CYCLES - 1);
    localparam logic [7:0]    SPACE   = 8'h20;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_COMMIT = 2'd1;
    localparam logic [1:0] S_PULSE  = 2'd2;
    localparam logic [1:0] S_HOLD   = 2'd3;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [7:0]      shadow_q  [0:31];
    logic [7:0]      display_q [0:31];
    logic            dirty_q,  dirty_d;
    logic [IDXW-1:0] rr_q,     rr_d;
    logic [CW-1:0]   cnt_q,    cnt_d;
    logic [1:0]      state_q,  state_d;
    logic            update_q, update_d;

    logic            period_done;
    logic            found;
    logic            wr_en;
    logic [IDXW-1:0] gnt_idx;
    logic [IDXW-1:0] cand;
    logic [4:0]      wr_addr_sel;
    logic [7:0]      wr_char_sel;

    // Computes (base + off) mod NREQ. Here off < NREQ, so one subtraction
    // is enough.
    function automatic logic [IDXW-1:0] wrap_add(input logic [IDXW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NREQ) s = s - NREQ;
        return IDXW'(s);
    endfunction

    // ------------------------------------------------------------------
    // Round-robin arbiter: first asserted request at or after rr_q.
    // ------------------------------------------------------------------
    always_comb begin
        found   = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = wrap_add(rr_q, i);
            if (!found && req_if.wr_req[cand]) begin
                found   = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    // clear_req outranks every requester and blocks the grant for one cycle.
    assign wr_en       = found && !req_if.clear_req;
    assign wr_addr_sel = req_if.wr_addr[gnt_idx];
    assign wr_char_sel = req_if.wr_char[gnt_idx];

    always_comb begin
        req_if.wr_gnt = '0;
        if (wr_en && !reset) begin
            req_if.wr_gnt = NREQ'(1'b1) << gnt_idx;
        end
    end

    assign rr_d = wr_en ? wrap_add(gnt_idx, 1) : rr_q;

    // ------------------------------------------------------------------
    // Refresh period counter and dirty flag
    // ------------------------------------------------------------------
    assign period_done = (cnt_q == CNT_MAX);

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == S_COMMIT) begin
            cnt_d = '0;
        end else if (!period_done) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // A write or clear that lands on the commit edge is not in the
    // snapshot. It must keep the frame dirty.
    always_comb begin
        dirty_d = dirty_q;
        if (req_if.clear_req || wr_en) begin
            dirty_d = 1'b1;
        end else if (state_q == S_COMMIT) begin
            dirty_d = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Commit FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (dirty_q && period_done && !LCDBusy) state_d = S_COMMIT;
            S_COMMIT: state_d = S_PULSE;
            S_PULSE:  state_d = S_HOLD;
            S_HOLD:   if (period_done) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // UpdateLCD is high for exactly the cycle spent in S_PULSE.
    assign update_d = (state_q == S_COMMIT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                shadow_q[i]  <= SPACE;
                display_q[i] <= SPACE;
            end
            dirty_q  <= 1'b1;
            rr_q     <= '0;
            cnt_q    <= CNT_MAX;
            state_q  <= S_IDLE;
            update_q <= 1'b0;
        end else begin
            if (req_if.clear_req) begin
                for (int i = 0; i < 32; i++) begin
                    shadow_q[i] <= SPACE;
                end
            end else if (wr_en) begin
                shadow_q[wr_addr_sel] <= wr_char_sel;
            end
            // Snapshot is the pre-edge shadow; a write on this edge waits.
            if (state_q == S_COMMIT) begin
                for (int i = 0; i < 32; i++) begin
                    display_q[i] <= shadow_q[i];
                end
            end
            dirty_q  <= dirty_d;
            rr_q     <= rr_d;
            cnt_q    <= cnt_d;
            state_q  <= state_d;
            update_q <= update_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign ASCII       = display_q;
    assign UpdateLCD   = update_q;
    assign Pending     = dirty_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_lcd_frame_scheduler.sv
module tb_lcd_frame_scheduler;

    localparam int NREQ = 2;
    localparam int RC   = 16;
    localparam logic [1:0] S_IDLE = 2'd0;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       LCDBusy = 1'b0;
    logic [7:0] ASCII [0:31];
    logic       UpdateLCD;
    logic       Pending;
    logic [1:0] dbg_state;

    lcd_frame_scheduler_if #(.NREQ(NREQ)) bus ();

    lcd_frame_scheduler #(
        .NREQ           (NREQ),
        .REFRESH_CYCLES (RC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_if      (bus),
        .LCDBusy     (LCDBusy),
        .ASCII       (ASCII),
        .UpdateLCD   (UpdateLCD),
        .Pending     (Pending),
        .dbg_state_o (dbg_state)
    );

    // ------------------------------------------------------------------
    // Clock / watchdog
    // ------------------------------------------------------------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ------------------------------------------------------------------
    // Scoreboard state
    // ------------------------------------------------------------------
    int         n_checks = 0;
    int         n_pass   = 0;
    logic [7:0] exp_mem [0:31];
    logic [1:0] exp_q [$];

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    function automatic logic [255:0] dut_frame();
        logic [255:0] f;
        for (int i = 0; i < 32; i++) f[i*8 +: 8] = ASCII[i];
        return f;
    endfunction

    function automatic logic [255:0] model_frame();
        logic [255:0] f;
        for (int i = 0; i < 32; i++) f[i*8 +: 8] = exp_mem[i];
        return f;
    endfunction

    function automatic logic [255:0] space_frame();
        logic [255:0] f;
        for (int i = 0; i < 32; i++) f[i*8 +: 8] = 8'h20;
        return f;
    endfunction

    // ------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns the tick count at which UpdateLCD was seen, or -1.
    task automatic wait_pulse(input int max_ticks, output int n);
        n = -1;
        for (int i = 1; i <= max_ticks; i++) begin
            tick();
            if (UpdateLCD) begin
                n = i;
                break;
            end
        end
    endtask

    // Waits until the frame is committed and the FSM is back in idle.
    task automatic settle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (dbg_state == S_IDLE && !Pending) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // ------------------------------------------------------------------
    // Monitor: pulse spacing and ASCII stability
    // ------------------------------------------------------------------
    bit           mon_en = 1'b0;
    int           cyc = 0;
    int           last_pulse;
    int           min_gap;
    int           n_pulses;
    int           n_bad_change;
    logic [255:0] prev_frame;

    always @(posedge clk) begin
        #1;
        cyc++;
        if (mon_en) begin
            if (UpdateLCD) begin
                if (last_pulse >= 0 && (cyc - last_pulse) < min_gap) min_gap = cyc - last_pulse;
                last_pulse = cyc;
                n_pulses++;
            end
            if (dut_frame() !== prev_frame && !UpdateLCD) n_bad_change++;
        end
        prev_frame = dut_frame();
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        int         n;
        bit         ok;
        logic [1:0] g;
        logic [7:0] c0, c1;
        int         gnt_errs;

        bus.wr_req    = '0;
        bus.wr_addr   = '0;
        bus.wr_char   = '0;
        bus.clear_req = 1'b0;
        for (int i = 0; i < 32; i++) exp_mem[i] = 8'h20;

        // ---- 1: reset state and first commit ----
        repeat (3) tick();
        check("t1_rst_frame", dut_frame(), space_frame());
        check("t1_rst_update", UpdateLCD, 0);
        check("t1_rst_pending", Pending, 1);
        check("t1_rst_gnt", bus.wr_gnt, 0);
        check("t1_rst_state", dbg_state, S_IDLE);
        reset = 1'b0;
        wait_pulse(3, n);
        check("t1_pulse_lat", n, 2);
        check("t1_frame", dut_frame(), space_frame());
        check("t1_pending", Pending, 0);
        tick();
        check("t1_pulse_width", UpdateLCD, 0);

        // ---- 2: simultaneous requests, rr=0 ----
        settle(ok);
        check("t2_settle", ok, 1);
        bus.wr_req     = 2'b11;
        bus.wr_addr[0] = 5'd0;
        bus.wr_char[0] = 8'h48;
        bus.wr_addr[1] = 5'd16;
        bus.wr_char[1] = 8'h69;
        #1;
        check("t2_gnt0", bus.wr_gnt, 2'b01);
        tick();
        exp_mem[0] = 8'h48;
        bus.wr_req = 2'b10;
        #1;
        check("t2_gnt1", bus.wr_gnt, 2'b10);
        tick();
        exp_mem[16] = 8'h69;
        bus.wr_req  = 2'b00;
        tick();
        check("t2_latency_pulse", UpdateLCD, 1);
        check("t2_frame", dut_frame(), model_frame());
        check("t2_pending", Pending, 0);

        // ---- 3: both requesters held, grants alternate ----
        settle(ok);
        check("t3_settle", ok, 1);
        for (int i = 0; i < 6; i++) exp_q.push_back((i % 2 == 0) ? 2'b01 : 2'b10);
        c0 = 8'h41;
        c1 = 8'h61;
        bus.wr_addr[0] = 5'd1;
        bus.wr_addr[1] = 5'd17;
        bus.wr_req     = 2'b11;
        for (int i = 0; i < 6; i++) begin
            bus.wr_char[0] = c0;
            bus.wr_char[1] = c1;
            #1;
            g = exp_q.pop_front();
            check("t3_gnt", bus.wr_gnt, g);
            tick();
            if (g == 2'b01) begin
                exp_mem[1] = c0;
                c0 = c0 + 8'd1;
            end else begin
                exp_mem[17] = c1;
                c1 = c1 + 8'd1;
            end
        end
        bus.wr_req = 2'b00;
        settle(ok);
        check("t3_settle_end", ok, 1);
        check("t3_frame", dut_frame(), model_frame());

        // ---- 4: write every cycle for 40 cycles ----
        last_pulse   = -1;
        min_gap      = 1000;
        n_pulses     = 0;
        n_bad_change = 0;
        gnt_errs     = 0;
        mon_en       = 1'b1;
        bus.wr_req   = 2'b01;
        for (int k = 0; k < 40; k++) begin
            bus.wr_addr[0] = 5'(k % 32);
            bus.wr_char[0] = 8'h30 + 8'(k);
            #1;
            if (bus.wr_gnt !== 2'b01) gnt_errs++;
            tick();
            exp_mem[k % 32] = 8'h30 + 8'(k);
        end
        bus.wr_req = 2'b00;
        settle(ok);
        mon_en = 1'b0;
        check("t4_settle", ok, 1);
        check("t4_gnt_errs", gnt_errs, 0);
        check("t4_pulses_ge2", (n_pulses >= 2), 1);
        check("t4_min_gap_ge_rc", (min_gap >= RC), 1);
        check("t4_ascii_stable", n_bad_change, 0);
        check("t4_frame", dut_frame(), model_frame());

        // ---- 5: clear with concurrent request; LCDBusy hold-off ----
        LCDBusy        = 1'b1;
        bus.clear_req  = 1'b1;
        bus.wr_req     = 2'b01;
        bus.wr_addr[0] = 5'd5;
        bus.wr_char[0] = 8'h5A;
        #1;
        check("t5_gnt_clear", bus.wr_gnt, 2'b00);
        tick();
        for (int i = 0; i < 32; i++) exp_mem[i] = 8'h20;
        bus.clear_req = 1'b0;
        #1;
        check("t5_gnt_after", bus.wr_gnt, 2'b01);
        tick();
        exp_mem[5] = 8'h5A;
        bus.wr_req = 2'b00;
        n = 0;
        for (int i = 0; i < 48; i++) begin
            tick();
            if (UpdateLCD) n++;
        end
        check("t5_no_pulse_busy", n, 0);
        check("t5_pending_busy", Pending, 1);
        LCDBusy = 1'b0;
        wait_pulse(5, n);
        check("t5_pulse_after_busy", n, 2);
        check("t5_frame", dut_frame(), model_frame());

        // ---- 6: reset during S_PULSE ----
        bus.wr_req     = 2'b01;
        bus.wr_addr[0] = 5'd31;
        bus.wr_char[0] = 8'h21;
        tick();
        exp_mem[31] = 8'h21;
        bus.wr_req = 2'b00;
        wait_pulse(40, n);
        check("t6_pulse_seen", (n > 0), 1);
        check("t6_frame_pre", dut_frame(), model_frame());
        reset = 1'b1;
        #1;
        check("t6_update_trunc", UpdateLCD, 0);
        check("t6_frame_reset", dut_frame(), space_frame());
        check("t6_pending_reset", Pending, 1);
        check("t6_state_reset", dbg_state, S_IDLE);
        tick();
        reset = 1'b0;
        wait_pulse(3, n);
        check("t6_pulse_after_reset", n, 2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
